// File: rtl/lc3_seq_control.sv
// LC-3 instruction-sequence control: Moore FSM driving datapath loads, gates, mux selects and
// SRAM strobes, with a shared read/write sub-sequence whose wait length is parameterised.
module lc3_seq_control #(
  parameter int unsigned READ_WAIT  = 2,
  parameter int unsigned WRITE_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic [1:0] DRMUX,
  output logic [1:0] SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic       MARMUX,
  output logic [1:0] ALUK,
  output logic       Mem_CE,
  output logic       Mem_UB,
  output logic       Mem_LB,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  typedef enum logic [4:0] {
    StHalted, StFetch, StMrd, StMwr, StFetchIr, StDecode,
    StAdd, StAnd, StNot, StBr, StBrTake, StJmp, StJsr, StJsrPc, StJsrrPc, StLea,
    StLd, StLdr, StLdi, StIndMar, StLoadWb, StSt, StStr, StSti, StStiMar, StStData,
    StTrap, StTrapMar, StTrapPc, StPause1, StPause2
  } state_e;

  localparam logic [3:0] RdLoad = 4'(READ_WAIT - 1);
  localparam logic [3:0] WrLoad = 4'(WRITE_WAIT - 1);

  state_e     state_q, ret_q;
  logic [3:0] wcnt_q;

  // ret_q and wcnt_q are loaded only on the transition into MRD/MWR.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StHalted;
      ret_q   <= StFetch;
      wcnt_q  <= '0;
    end else begin
      unique case (state_q)
        StHalted:  if (Run) state_q <= StFetch;
        StFetch:   begin ret_q <= StFetchIr; wcnt_q <= RdLoad; state_q <= StMrd; end
        StMrd:     if (wcnt_q == 4'd0) state_q <= ret_q; else wcnt_q <= wcnt_q - 4'd1;
        StMwr:     if (wcnt_q == 4'd0) state_q <= StFetch; else wcnt_q <= wcnt_q - 4'd1;
        StFetchIr: state_q <= StDecode;
        StDecode: begin
          unique case (Opcode)
            4'b0000: state_q <= StBr;
            4'b0001: state_q <= StAdd;
            4'b0010: state_q <= StLd;
            4'b0011: state_q <= StSt;
            4'b0100: state_q <= StJsr;
            4'b0101: state_q <= StAnd;
            4'b0110: state_q <= StLdr;
            4'b0111: state_q <= StStr;
            4'b1000: state_q <= StPause1;
            4'b1001: state_q <= StNot;
            4'b1010: state_q <= StLdi;
            4'b1011: state_q <= StSti;
            4'b1100: state_q <= StJmp;
            4'b1101: state_q <= StPause1;
            4'b1110: state_q <= StLea;
            4'b1111: state_q <= StTrap;
          endcase
        end
        StBr:      state_q <= BEN ? StBrTake : StFetch;
        StJsr:     state_q <= IR_11 ? StJsrPc : StJsrrPc;
        StLd, StLdr: begin ret_q <= StLoadWb; wcnt_q <= RdLoad; state_q <= StMrd; end
        StLdi:     begin ret_q <= StIndMar; wcnt_q <= RdLoad; state_q <= StMrd; end
        StIndMar:  begin ret_q <= StLoadWb; wcnt_q <= RdLoad; state_q <= StMrd; end
        StSt, StStr, StStiMar: state_q <= StStData;
        StSti:     begin ret_q <= StStiMar; wcnt_q <= RdLoad; state_q <= StMrd; end
        StStData:  begin wcnt_q <= WrLoad; state_q <= StMwr; end
        StTrap:    state_q <= StTrapMar;
        StTrapMar: begin ret_q <= StTrapPc; wcnt_q <= RdLoad; state_q <= StMrd; end
        StPause1:  if (Continue) state_q <= StPause2;
        StPause2:  if (!Continue) state_q <= StFetch;
        StAdd, StAnd, StNot, StBrTake, StJmp, StJsrPc, StJsrrPc, StLea, StLoadWb, StTrapPc:
          state_q <= StFetch;
        default:   state_q <= StHalted;
      endcase
    end
  end

  assign Mem_CE = 1'b0;
  assign Mem_UB = 1'b0;
  assign Mem_LB = 1'b0;

  always_comb begin
    LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
    LD_CC = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
    GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
    PCMUX = 2'b00; DRMUX = 2'b00; SR1MUX = 2'b00; SR2MUX = 1'b0;
    ADDR1MUX = 1'b0; ADDR2MUX = 2'b00; MARMUX = 1'b0; ALUK = 2'b00;
    Mem_OE = 1'b1; Mem_WE = 1'b1;
    unique case (state_q)
      StFetch:   begin GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; end
      StMrd:     begin Mem_OE = 1'b0; LD_MDR = (wcnt_q == 4'd0); end
      StMwr:     begin Mem_WE = 1'b0; GateMDR = 1'b1; end
      StFetchIr: begin GateMDR = 1'b1; LD_IR = 1'b1; end
      StDecode:  LD_BEN = 1'b1;
      StAdd, StAnd, StNot: begin
        GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; SR1MUX = 2'b01; SR2MUX = ~IR_5;
        ALUK = (state_q == StAnd) ? 2'b01 : (state_q == StNot) ? 2'b10 : 2'b00;
      end
      StBrTake: begin LD_PC = 1'b1; PCMUX = 2'b01; ADDR1MUX = 1'b1; ADDR2MUX = 2'b01; end
      StJmp: begin SR1MUX = 2'b01; ALUK = 2'b11; GateALU = 1'b1; PCMUX = 2'b10; LD_PC = 1'b1; end
      StJsr, StTrap: begin GatePC = 1'b1; LD_REG = 1'b1; DRMUX = 2'b10; end
      StJsrPc: begin LD_PC = 1'b1; PCMUX = 2'b01; ADDR1MUX = 1'b1; ADDR2MUX = 2'b00; end
      StJsrrPc: begin
        ADDR2MUX = 2'b11; SR1MUX = 2'b01; PCMUX = 2'b01; LD_PC = 1'b1;
      end
      StLea: begin
        GateMARMUX = 1'b1; MARMUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = 2'b01;
        LD_REG = 1'b1; LD_CC = 1'b1;
      end
      StLd, StLdi, StSt, StSti: begin
        LD_MAR = 1'b1; GateMARMUX = 1'b1; MARMUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = 2'b01;
      end
      StLdr, StStr: begin
        LD_MAR = 1'b1; GateMARMUX = 1'b1; MARMUX = 1'b1; ADDR2MUX = 2'b10; SR1MUX = 2'b01;
      end
      StIndMar, StStiMar: begin GateMDR = 1'b1; LD_MAR = 1'b1; end
      StLoadWb: begin GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; end
      StStData: begin ALUK = 2'b11; GateALU = 1'b1; LD_MDR = 1'b1; end
      StTrapMar: begin GateMARMUX = 1'b1; LD_MAR = 1'b1; end
      StTrapPc: begin GateMDR = 1'b1; PCMUX = 2'b10; LD_PC = 1'b1; end
      StPause1, StPause2: LD_LED = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lc3_seq_control.sv
// Directed bench: instance a (READ_WAIT=2) covers fetch and execute paths,
// instance b (READ_WAIT=5, WRITE_WAIT=3) covers the STI wait lengths.
module tb_lc3_seq_control;

  logic       Clk = 1'b0;
  logic       reset_a, reset_b, Run, Continue, IR_5, IR_11, BEN;
  logic [3:0] Opcode;
  int         vectors = 0;
  int         miscompares = 0;

  logic a_LD_MAR, a_LD_MDR, a_LD_IR, a_LD_BEN, a_LD_CC, a_LD_REG, a_LD_PC, a_LD_LED;
  logic a_GatePC, a_GateMDR, a_GateALU, a_GateMARMUX, a_SR2MUX, a_ADDR1MUX, a_MARMUX;
  logic [1:0] a_PCMUX, a_DRMUX, a_SR1MUX, a_ADDR2MUX, a_ALUK;
  logic a_Mem_CE, a_Mem_UB, a_Mem_LB, a_Mem_OE, a_Mem_WE;

  logic b_LD_MAR, b_LD_MDR, b_LD_IR, b_LD_BEN, b_LD_CC, b_LD_REG, b_LD_PC, b_LD_LED;
  logic b_GatePC, b_GateMDR, b_GateALU, b_GateMARMUX, b_SR2MUX, b_ADDR1MUX, b_MARMUX;
  logic [1:0] b_PCMUX, b_DRMUX, b_SR1MUX, b_ADDR2MUX, b_ALUK;
  logic b_Mem_CE, b_Mem_UB, b_Mem_LB, b_Mem_OE, b_Mem_WE;

  always #5 Clk = ~Clk;

  lc3_seq_control #(.READ_WAIT(2), .WRITE_WAIT(2)) dut_a (
    .Clk(Clk), .Reset(reset_a), .Run(Run), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(a_LD_MAR), .LD_MDR(a_LD_MDR), .LD_IR(a_LD_IR), .LD_BEN(a_LD_BEN),
    .LD_CC(a_LD_CC), .LD_REG(a_LD_REG), .LD_PC(a_LD_PC), .LD_LED(a_LD_LED),
    .GatePC(a_GatePC), .GateMDR(a_GateMDR), .GateALU(a_GateALU), .GateMARMUX(a_GateMARMUX),
    .PCMUX(a_PCMUX), .DRMUX(a_DRMUX), .SR1MUX(a_SR1MUX), .SR2MUX(a_SR2MUX),
    .ADDR1MUX(a_ADDR1MUX), .ADDR2MUX(a_ADDR2MUX), .MARMUX(a_MARMUX), .ALUK(a_ALUK),
    .Mem_CE(a_Mem_CE), .Mem_UB(a_Mem_UB), .Mem_LB(a_Mem_LB), .Mem_OE(a_Mem_OE),
    .Mem_WE(a_Mem_WE)
  );

  lc3_seq_control #(.READ_WAIT(5), .WRITE_WAIT(3)) dut_b (
    .Clk(Clk), .Reset(reset_b), .Run(Run), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(b_LD_MAR), .LD_MDR(b_LD_MDR), .LD_IR(b_LD_IR), .LD_BEN(b_LD_BEN),
    .LD_CC(b_LD_CC), .LD_REG(b_LD_REG), .LD_PC(b_LD_PC), .LD_LED(b_LD_LED),
    .GatePC(b_GatePC), .GateMDR(b_GateMDR), .GateALU(b_GateALU), .GateMARMUX(b_GateMARMUX),
    .PCMUX(b_PCMUX), .DRMUX(b_DRMUX), .SR1MUX(b_SR1MUX), .SR2MUX(b_SR2MUX),
    .ADDR1MUX(b_ADDR1MUX), .ADDR2MUX(b_ADDR2MUX), .MARMUX(b_MARMUX), .ALUK(b_ALUK),
    .Mem_CE(b_Mem_CE), .Mem_UB(b_Mem_UB), .Mem_LB(b_Mem_LB), .Mem_OE(b_Mem_OE),
    .Mem_WE(b_Mem_WE)
  );

  // Bus exclusivity and strobe exclusivity, checked every cycle on a live instance.
  always @(negedge Clk) begin
    if (!reset_a) begin
      vectors++;
      if (({1'b0, a_GatePC} + a_GateMDR + a_GateALU + a_GateMARMUX) > 2'd1 ||
          (!a_Mem_OE && !a_Mem_WE)) begin
        miscompares++;
        $display("FAIL a_exclusive: gates=%b%b%b%b oe=%b we=%b, at most one gate and one strobe",
                 a_GatePC, a_GateMDR, a_GateALU, a_GateMARMUX, a_Mem_OE, a_Mem_WE);
      end
    end
    if (!reset_b) begin
      vectors++;
      if (({1'b0, b_GatePC} + b_GateMDR + b_GateALU + b_GateMARMUX) > 2'd1 ||
          (!b_Mem_OE && !b_Mem_WE)) begin
        miscompares++;
        $display("FAIL b_exclusive: gates=%b%b%b%b oe=%b we=%b, at most one gate and one strobe",
                 b_GatePC, b_GateMDR, b_GateALU, b_GateMARMUX, b_Mem_OE, b_Mem_WE);
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic bit a_at_fetch();
    return a_GatePC && a_LD_MAR && a_LD_PC && (a_PCMUX == 2'b00) && a_Mem_OE;
  endfunction

  // From FETCH on instance a, step to the first execute cycle of opcode op.
  task automatic fetch_to_exec(input logic [3:0] op);
    Opcode = op;
    repeat (5) tick();
  endtask

  task automatic test_reset();
    logic [11:0] act;
    act = {a_LD_MAR, a_LD_MDR, a_LD_IR, a_LD_BEN, a_LD_CC, a_LD_REG, a_LD_PC, a_LD_LED,
           a_GatePC, a_GateMDR, a_GateALU, a_GateMARMUX};
    vectors++;
    if (act !== 12'h000 || a_Mem_OE !== 1'b1 || a_Mem_WE !== 1'b1 ||
        {a_Mem_CE, a_Mem_UB, a_Mem_LB} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_outputs: loads/gates=%h oe=%b we=%b ce/ub/lb=%b%b%b, need 000 1 1 000",
               act, a_Mem_OE, a_Mem_WE, a_Mem_CE, a_Mem_UB, a_Mem_LB);
    end
  endtask

  task automatic test_fetch();
    Opcode = 4'b0001; IR_5 = 1'b1;
    reset_a = 1'b0; Run = 1'b1;
    #1;
    vectors++;
    if (a_at_fetch() !== 1'b0 || a_LD_PC !== 1'b0) begin
      miscompares++; $display("FAIL halted_cycle0: fetch signature seen, need HALTED");
    end
    tick();  // cycle 1
    Run = 1'b0;
    vectors++;
    if (a_at_fetch() !== 1'b1) begin
      miscompares++; $display("FAIL fetch_cycle1: fetch=%b, need 1", a_at_fetch());
    end
    tick();  // cycle 2
    vectors++;
    if (a_Mem_OE !== 1'b0 || a_LD_MDR !== 1'b0) begin
      miscompares++; $display("FAIL mrd_cycle2: oe=%b ld_mdr=%b, need 0 0", a_Mem_OE, a_LD_MDR);
    end
    tick();  // cycle 3
    vectors++;
    if (a_Mem_OE !== 1'b0 || a_LD_MDR !== 1'b1) begin
      miscompares++; $display("FAIL mrd_cycle3: oe=%b ld_mdr=%b, need 0 1", a_Mem_OE, a_LD_MDR);
    end
    tick();  // cycle 4
    vectors++;
    if (a_LD_IR !== 1'b1 || a_GateMDR !== 1'b1 || a_Mem_OE !== 1'b1 || a_LD_MDR !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_ir_cycle4: ld_ir=%b gate_mdr=%b oe=%b ld_mdr=%b, need 1 1 1 0",
               a_LD_IR, a_GateMDR, a_Mem_OE, a_LD_MDR);
    end
    tick();  // cycle 5
    vectors++;
    if (a_LD_BEN !== 1'b1 || a_LD_IR !== 1'b0) begin
      miscompares++; $display("FAIL decode_cycle5: ld_ben=%b ld_ir=%b, need 1 0", a_LD_BEN, a_LD_IR);
    end
    tick();  // ADD execute
    tick();
    vectors++;
    if (a_at_fetch() !== 1'b1) begin
      miscompares++; $display("FAIL add_to_fetch: fetch=%b, need 1", a_at_fetch());
    end
  endtask

  task automatic test_alu();
    logic [3:0] ops [3];
    logic [1:0] aluks [3];
    logic       ir5s [3];
    ops = '{4'b0001, 4'b0101, 4'b1001};
    aluks = '{2'b00, 2'b01, 2'b10};
    ir5s = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      IR_5 = ir5s[i];
      fetch_to_exec(ops[i]);
      vectors++;
      if ({a_GateALU, a_LD_REG, a_LD_CC} !== 3'b111 || a_ALUK !== aluks[i] ||
          a_SR1MUX !== 2'b01 || a_SR2MUX !== ~ir5s[i]) begin
        miscompares++;
        $display("FAIL alu_op%0d: gate/reg/cc=%b%b%b aluk=%b sr1=%b sr2=%b, need 111 %b 01 %b",
                 i, a_GateALU, a_LD_REG, a_LD_CC, a_ALUK, a_SR1MUX, a_SR2MUX, aluks[i], ~ir5s[i]);
      end
      tick();
      vectors++;
      if (a_at_fetch() !== 1'b1) begin
        miscompares++; $display("FAIL alu_op%0d_next: fetch=%b, need 1", i, a_at_fetch());
      end
    end
  endtask

  task automatic test_br();
    BEN = 1'b0;
    fetch_to_exec(4'b0000);
    vectors++;
    if (a_LD_PC !== 1'b0) begin
      miscompares++; $display("FAIL br_nt_check: ld_pc=%b, need 0", a_LD_PC);
    end
    tick();
    vectors++;
    if (a_at_fetch() !== 1'b1) begin
      miscompares++; $display("FAIL br_nt_fetch: fetch=%b, need 1", a_at_fetch());
    end
    BEN = 1'b1;
    fetch_to_exec(4'b0000);
    vectors++;
    if (a_LD_PC !== 1'b0) begin
      miscompares++; $display("FAIL br_t_check: ld_pc=%b, need 0", a_LD_PC);
    end
    tick();
    vectors++;
    if (a_LD_PC !== 1'b1 || a_PCMUX !== 2'b01 || a_ADDR2MUX !== 2'b01 || a_ADDR1MUX !== 1'b1) begin
      miscompares++;
      $display("FAIL br_take: ld_pc=%b pcmux=%b addr2=%b addr1=%b, need 1 01 01 1",
               a_LD_PC, a_PCMUX, a_ADDR2MUX, a_ADDR1MUX);
    end
    tick();
    vectors++;
    if (a_at_fetch() !== 1'b1) begin
      miscompares++; $display("FAIL br_t_fetch: fetch=%b, need 1", a_at_fetch());
    end
    BEN = 1'b0;
  endtask

  task automatic test_jsr();
    for (int i = 0; i < 2; i++) begin
      IR_11 = (i == 0);
      fetch_to_exec(4'b0100);
      vectors++;
      if (a_DRMUX !== 2'b10 || a_LD_REG !== 1'b1 || a_GatePC !== 1'b1 || a_LD_PC !== 1'b0) begin
        miscompares++;
        $display("FAIL jsr%0d_link: drmux=%b ld_reg=%b gate_pc=%b ld_pc=%b, need 10 1 1 0",
                 i, a_DRMUX, a_LD_REG, a_GatePC, a_LD_PC);
      end
      tick();
      vectors++;
      if (i == 0) begin
        if (a_LD_PC !== 1'b1 || a_PCMUX !== 2'b01 || a_ADDR1MUX !== 1'b1 ||
            a_ADDR2MUX !== 2'b00) begin
          miscompares++;
          $display("FAIL jsr_pc: ld_pc=%b pcmux=%b addr1=%b addr2=%b, need 1 01 1 00",
                   a_LD_PC, a_PCMUX, a_ADDR1MUX, a_ADDR2MUX);
        end
      end else begin
        if (a_LD_PC !== 1'b1 || a_PCMUX !== 2'b01 || a_ADDR1MUX !== 1'b0 ||
            a_ADDR2MUX !== 2'b11 || a_SR1MUX !== 2'b01) begin
          miscompares++;
          $display("FAIL jsrr_pc: ld_pc=%b pcmux=%b addr1=%b addr2=%b sr1=%b, need 1 01 0 11 01",
                   a_LD_PC, a_PCMUX, a_ADDR1MUX, a_ADDR2MUX, a_SR1MUX);
        end
      end
      tick();
      vectors++;
      if (a_at_fetch() !== 1'b1) begin
        miscompares++; $display("FAIL jsr%0d_fetch: fetch=%b, need 1", i, a_at_fetch());
      end
    end
  endtask

  task automatic test_trap();
    fetch_to_exec(4'b1111);
    tick();
    vectors++;
    if (a_GateMARMUX !== 1'b1 || a_MARMUX !== 1'b0 || a_LD_MAR !== 1'b1) begin
      miscompares++;
      $display("FAIL trap_mar: gate_marmux=%b marmux=%b ld_mar=%b, need 1 0 1",
               a_GateMARMUX, a_MARMUX, a_LD_MAR);
    end
    repeat (3) tick();
    vectors++;
    if (a_GateMDR !== 1'b1 || a_PCMUX !== 2'b10 || a_LD_PC !== 1'b1 || a_Mem_OE !== 1'b1) begin
      miscompares++;
      $display("FAIL trap_pc: gate_mdr=%b pcmux=%b ld_pc=%b oe=%b, need 1 10 1 1",
               a_GateMDR, a_PCMUX, a_LD_PC, a_Mem_OE);
    end
    tick();
  endtask

  task automatic test_pause();
    int bad;
    Continue = 1'b0;
    fetch_to_exec(4'b1101);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (a_LD_LED !== 1'b1 || a_at_fetch()) bad++;
      tick();
    end
    vectors++;
    if (bad != 0 || a_LD_LED !== 1'b1) begin
      miscompares++; $display("FAIL pause1_hold: %0d bad cycles, need 0", bad);
    end
    Continue = 1'b1;
    repeat (3) tick();
    vectors++;
    if (a_LD_LED !== 1'b1) begin
      miscompares++; $display("FAIL pause2_hold: ld_led=%b, need 1", a_LD_LED);
    end
    Continue = 1'b0;
    tick();
    vectors++;
    if (a_at_fetch() !== 1'b1 || a_LD_LED !== 1'b0) begin
      miscompares++;
      $display("FAIL pause_release: fetch=%b ld_led=%b, need 1 0", a_at_fetch(), a_LD_LED);
    end
  endtask

  task automatic test_ldi_reset();
    int bad;
    fetch_to_exec(4'b1010);
    tick();
    tick();  // second MRD cycle
    vectors++;
    if (a_Mem_OE !== 1'b0) begin
      miscompares++; $display("FAIL ldi_mrd2: oe=%b, need 0", a_Mem_OE);
    end
    #2 reset_a = 1'b1;
    #1;
    vectors++;
    if (a_Mem_OE !== 1'b1 || a_Mem_WE !== 1'b1) begin
      miscompares++;
      $display("FAIL async_release: oe=%b we=%b, need 1 1", a_Mem_OE, a_Mem_WE);
    end
    tick();
    Run = 1'b0;
    reset_a = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (a_LD_REG !== 1'b0 || a_LD_MAR !== 1'b0 || a_Mem_OE !== 1'b1) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++; $display("FAIL post_reset_halted: %0d bad cycles, need 0", bad);
    end
    reset_a = 1'b1;
  endtask

  task automatic test_sti_wait();
    int oe_cnt, we_cnt;
    Opcode = 4'b1011;
    reset_b = 1'b0;
    Run = 1'b1;
    tick();  // FETCH
    Run = 1'b0;
    repeat (8) tick();  // MRD x5, FETCH_IR, DECODE, STI
    vectors++;
    if (b_LD_MAR !== 1'b1 || b_GateMARMUX !== 1'b1 || b_ADDR2MUX !== 2'b01 || b_MARMUX !== 1'b1) begin
      miscompares++;
      $display("FAIL sti_addr: ld_mar=%b gate_marmux=%b addr2=%b marmux=%b, need 1 1 01 1",
               b_LD_MAR, b_GateMARMUX, b_ADDR2MUX, b_MARMUX);
    end
    oe_cnt = 0;
    tick();
    while (b_Mem_OE === 1'b0 && oe_cnt < 20) begin
      oe_cnt++;
      tick();
    end
    vectors++;
    if (oe_cnt != 5) begin
      miscompares++; $display("FAIL sti_oe_len: %0d low cycles, need 5", oe_cnt);
    end
    vectors++;
    if (b_GateMDR !== 1'b1 || b_LD_MAR !== 1'b1) begin
      miscompares++;
      $display("FAIL sti_mar: gate_mdr=%b ld_mar=%b, need 1 1", b_GateMDR, b_LD_MAR);
    end
    tick();
    vectors++;
    if (b_GateALU !== 1'b1 || b_LD_MDR !== 1'b1 || b_ALUK !== 2'b11 || b_SR1MUX !== 2'b00) begin
      miscompares++;
      $display("FAIL st_data: gate_alu=%b ld_mdr=%b aluk=%b sr1=%b, need 1 1 11 00",
               b_GateALU, b_LD_MDR, b_ALUK, b_SR1MUX);
    end
    we_cnt = 0;
    tick();
    while (b_Mem_WE === 1'b0 && b_GateMDR === 1'b1 && we_cnt < 20) begin
      we_cnt++;
      tick();
    end
    vectors++;
    if (we_cnt != 3) begin
      miscompares++; $display("FAIL sti_we_len: %0d low cycles, need 3", we_cnt);
    end
    vectors++;
    if (!(b_GatePC && b_LD_MAR && b_LD_PC && b_Mem_WE)) begin
      miscompares++;
      $display("FAIL sti_fetch: gate_pc=%b ld_mar=%b ld_pc=%b we=%b, need 1 1 1 1",
               b_GatePC, b_LD_MAR, b_LD_PC, b_Mem_WE);
    end
    reset_b = 1'b1;
  endtask

  initial begin
    reset_a = 1'b1; reset_b = 1'b1; Run = 1'b0; Continue = 1'b0;
    Opcode = 4'b0000; IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;
    tick();
    tick();
    test_reset();
    test_fetch();
    test_alu();
    test_br();
    test_jsr();
    test_trap();
    test_pause();
    test_ldi_reset();
    test_sti_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
